// File: rtl/uart_tx.sv
// UART transmitter: serializes one parallel word per frame (start, data LSB first,
// optional parity, one or two stop bits) with a registered, idle-high serial line.
module uart_tx #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT     = 16,
  parameter int PARITY_EN        = 0,
  parameter int PARITY_ODD       = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_valid,
  input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [2:0]                  dbg_state_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(INPUT_DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(INPUT_DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Initial values mirror the reset values so simulation and formal start from IDLE.
  state_e                      state_q  = S_IDLE;
  state_e                      state_d;
  logic [CNT_W-1:0]            cnt_q    = '0;
  logic [CNT_W-1:0]            cnt_d;
  logic [BIT_W-1:0]            bit_q    = '0;
  logic [BIT_W-1:0]            bit_d;
  logic                        stop_q   = 1'b0;
  logic                        stop_d;
  logic [INPUT_DATA_WIDTH-1:0] shift_q  = '0;
  logic [INPUT_DATA_WIDTH-1:0] shift_d;
  logic                        parity_q = 1'b0;
  logic                        parity_d;
  logic                        serial_q = 1'b1;
  logic                        serial_d;
  logic                        bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
    end
  end

  // Handshake: a word transfers on any rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so anything presented while busy is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_end  = (cnt_q == CNT_LAST);
    tx_done  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ 1'(PARITY_ODD);
          bit_d    = '0;
          stop_d   = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            tx_done = 1'b1;
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    unique case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign tx_busy     = (state_q != S_IDLE);
  assign serial_out  = serial_q;
  assign dbg_state_o = state_q;

endmodule
